decrypter_core: RTL and testbench

- Receiver-side counterpart of the 96-bit encryption frame. It accepts one encrypted frame, checks parity, extracts the embedded random fields, and applies the inverse of the selected encryption function. It returns the 80-bit plaintext.
- Multi-cycle iterative engine with valid/ready handshakes on input and output. One frame is in flight at a time.

---
 rtl/decrypt_pkg.sv | 45 ++++
 rtl/dec_rotator.sv | 60 ++++++
 rtl/decrypter_core.sv | 153 +++++++++++++++
 tb/tb_decrypter_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared types, frame field positions and key/parity helpers
// for the 96-bit frame decrypter.
package decrypt_pkg;

  localparam int FRAME_W   = 96;
  localparam int PAYLOAD_W = 80;
  localparam int PAR_BIT   = 95;
  localparam int R9_MSB    = 94;
  localparam int R9_LSB    = 86;
  localparam int R6_MSB    = 85;
  localparam int R6_LSB    = 80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ROTATE,
    S_XOR,
    S_SUB,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_XOR,
    MODE_ROT6,
    MODE_ROTXOR,
    MODE_BYTESUB
  } mode_e;

  function automatic logic [PAYLOAD_W-1:0] expand_key(
    input logic [8:0] r9,
    input logic [5:0] r6
  );
    logic [14:0] k15;
    k15 = {r9, r6};
    return {k15[4:0], {5{k15}}};
  endfunction

  // 1 means the even-parity check failed
  function automatic logic frame_parity(
    input logic [FRAME_W-1:0] f
  );
    return f[PAR_BIT] ^ (^f[PAR_BIT-1:0]);
  endfunction

endpackage

// File: rtl/dec_rotator.sv
// dec_rotator: loadable 80-bit right rotator, ROT_STEP bits per enable,
// with a step down-counter; last_o marks the final rotate step.
module dec_rotator #(
  parameter int ROT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [79:0] data_i,
  input  logic [5:0]  amt_i,
  input  logic        en_i,
  output logic [79:0] data_o,
  output logic [79:0] nxt_o,
  output logic        last_o
);

  logic [79:0]  data_q, data_d;
  logic [5:0]   rem_q, rem_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [5:0]   sh;
  logic [6:0]   amt_up;
  logic [159:0] wide;

  // next rotation value, load and step bookkeeping
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    sh     = (rem_q < 6'(ROT_STEP)) ? rem_q : 6'(ROT_STEP);
    wide   = {data_q, data_q} >> sh;
    amt_up = {1'b0, amt_i} + 7'(ROT_STEP - 1);
    if (load_i) begin
      data_d = data_i;
      rem_d  = amt_i;
      cnt_d  = (amt_i == 6'd0) ? 6'd1 : 6'(amt_up / 7'(ROT_STEP));
    end else if (en_i && cnt_q != 6'd0) begin
      data_d = wide[79:0];
      rem_d  = rem_q - sh;
      cnt_d  = cnt_q - 6'd1;
    end
  end

  // rotator state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign nxt_o  = wide[79:0];
  assign last_o = (cnt_q == 6'd1);

endmodule

// File: rtl/decrypter_core.sv
// decrypter_core: iterative inverse of the 96-bit encryption frame,
// one frame in flight, valid/ready on both sides.
module decrypter_core
  import decrypt_pkg::*;
#(
  parameter int ROT_STEP = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAME_W-1:0]   data_to_be_decrypt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] output_decrypted,
  output logic                 out_err,
  output logic                 busy
);

  state_e                 state_q, state_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [PAYLOAD_W-1:0]   res_q, res_d;
  logic                   err_q, err_d;

  logic [8:0]             r9;
  logic [5:0]             r6;
  logic [PAYLOAD_W-1:0]   payload;
  logic [PAYLOAD_W-1:0]   key;
  mode_e                  mode;

  logic                   rot_ld, rot_en, rot_last;
  logic [5:0]             rot_amt;
  logic [PAYLOAD_W-1:0]   rot_q, rot_nxt;
  logic [PAYLOAD_W-1:0]   sub;
  logic [PAYLOAD_W-1:0]   xsrc;

  assign r9      = frame_q[R9_MSB:R9_LSB];
  assign r6      = frame_q[R6_MSB:R6_LSB];
  assign payload = frame_q[PAYLOAD_W-1:0];
  assign mode    = mode_e'(r6[1:0]);
  assign key     = expand_key(r9, r6);
  assign rot_amt = (mode == MODE_ROT6) ? r6 : r9[5:0];
  assign xsrc    = (mode == MODE_ROTXOR) ? rot_q : payload;

  dec_rotator #(
    .ROT_STEP (ROT_STEP)
  ) u_rot (
    .clk    (Clk),
    .rst    (Rst),
    .load_i (rot_ld),
    .data_i (payload),
    .amt_i  (rot_amt),
    .en_i   (rot_en),
    .data_o (rot_q),
    .nxt_o  (rot_nxt),
    .last_o (rot_last)
  );

  // bytewise subtract; no borrow crosses byte lanes
  always_comb begin
    sub = '0;
    for (int i = 0; i < 10; i++) begin
      sub[8*i +: 8] = payload[8*i +: 8] - r9[7:0];
    end
  end

  // next state, result capture and rotator control
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    res_d   = res_q;
    err_d   = err_q;
    rot_ld  = 1'b0;
    rot_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          frame_d = data_to_be_decrypt;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (frame_parity(frame_q)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          unique case (mode)
            MODE_XOR:     state_d = S_XOR;
            MODE_ROT6,
            MODE_ROTXOR: begin
              rot_ld  = 1'b1;
              state_d = S_ROTATE;
            end
            MODE_BYTESUB: state_d = S_SUB;
          endcase
        end
      end
      S_ROTATE: begin
        rot_en = 1'b1;
        if (rot_last) begin
          if (mode == MODE_ROT6) begin
            res_d   = rot_nxt;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_XOR;
          end
        end
      end
      S_XOR: begin
        res_d   = xsrc ^ key;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_SUB: begin
        res_d   = sub;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          res_d   = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE) && !Rst;
  assign out_valid        = (state_q == S_DONE);
  assign output_decrypted = res_q;
  assign out_err          = err_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_decrypter_core.sv
// tb_decrypter_core: directed vectors for decrypter_core with
// ROT_STEP=1 (dut) and ROT_STEP=4 (dut4) instances.
module tb_decrypter_core;

  logic        Clk;
  logic        Rst;
  logic        iv, iv4;
  logic        in_ready, in_ready4;
  logic [95:0] data, data4;
  logic        out_valid, out_valid4;
  logic        ordy, ordy4;
  logic [79:0] out, out4;
  logic        err, err4;
  logic        busy, busy4;

  int n_run  = 0;
  int n_fail = 0;

  decrypter_core #(.ROT_STEP(1)) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .in_valid           (iv),
    .in_ready           (in_ready),
    .data_to_be_decrypt (data),
    .out_valid          (out_valid),
    .out_ready          (ordy),
    .output_decrypted   (out),
    .out_err            (err),
    .busy               (busy)
  );

  decrypter_core #(.ROT_STEP(4)) dut4 (
    .Clk                (Clk),
    .Rst                (Rst),
    .in_valid           (iv4),
    .in_ready           (in_ready4),
    .data_to_be_decrypt (data4),
    .out_valid          (out_valid4),
    .out_ready          (ordy4),
    .output_decrypted   (out4),
    .out_err            (err4),
    .busy               (busy4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] k80(input logic [8:0] r9,
                                      input logic [5:0] r6);
    logic [14:0] k;
    k = {r9, r6};
    return {k[4:0], k, k, k, k, k};
  endfunction

  function automatic logic [95:0] mk(input logic [8:0] r9,
                                     input logic [5:0] r6,
                                     input logic [79:0] c);
    return {^{r9, r6, c}, r9, r6, c};
  endfunction

  function automatic logic [79:0] rotl80(input logic [79:0] x,
                                         input int s);
    logic [159:0] w;
    w = {x, x} << s;
    return w[159:80];
  endfunction

  task automatic accept(input bit sel, input logic [95:0] f);
    int  n;
    logic r;
    n = 0;
    @(negedge Clk);
    r = sel ? in_ready4 : in_ready;
    while (!r && n < 200) begin
      @(negedge Clk);
      n++;
      r = sel ? in_ready4 : in_ready;
    end
    chk("accept_ready", {95'b0, r}, 96'd1);
    if (sel) begin
      data4 = f;
      iv4   = 1'b1;
    end else begin
      data = f;
      iv   = 1'b1;
    end
    @(posedge Clk);
    #1;
    iv  = 1'b0;
    iv4 = 1'b0;
  endtask

  task automatic wait_out(input bit sel, output int lat);
    lat = 1;
    while (!(sel ? out_valid4 : out_valid) && lat < 200) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  logic [79:0] p2, c2;
  logic [95:0] f0, f2;
  int          lat;
  bit          seen;

  initial begin
    Rst   = 1'b1;
    iv    = 1'b0;
    iv4   = 1'b0;
    data  = '0;
    data4 = '0;
    ordy  = 1'b1;
    ordy4 = 1'b1;

    // reset / idle
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_in_ready", {95'b0, in_ready}, 96'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("rst_in_ready_after", {95'b0, in_ready}, 96'd1);
    chk("rst_out_valid", {95'b0, out_valid}, 96'd0);
    chk("rst_busy", {95'b0, busy}, 96'd0);
    chk("rst_data", {16'b0, out}, 96'd0);
    chk("rst_err", {95'b0, err}, 96'd0);
    chk("rst_busy4", {95'b0, busy4}, 96'd0);

    // mode 0: C = K80 -> P = 0
    f0 = mk(9'h1FF, 6'h04, k80(9'h1FF, 6'h04));
    accept(0, f0);
    wait_out(0, lat);
    chk("m0_lat", 96'(lat), 96'd3);
    chk("m0_data", {16'b0, out}, 96'd0);
    chk("m0_err", {95'b0, err}, 96'd0);

    // mode 1, ROT_STEP 1 and 4
    accept(0, mk(9'h000, 6'h05, 80'h20));
    wait_out(0, lat);
    chk("m1_lat", 96'(lat), 96'd7);
    chk("m1_data", {16'b0, out}, 96'd1);
    accept(1, mk(9'h000, 6'h05, 80'h20));
    wait_out(1, lat);
    chk("m1s4_lat", 96'(lat), 96'd4);
    chk("m1s4_data", {16'b0, out4}, 96'd1);

    // mode 3: 0x02 - 0xF3 = 0x0F per byte
    accept(0, mk(9'h0F3, 6'h03, {10{8'h02}}));
    wait_out(0, lat);
    chk("m3_lat", 96'(lat), 96'd3);
    chk("m3_data", {16'b0, out}, {16'b0, {10{8'h0F}}});
    chk("m3_err", {95'b0, err}, 96'd0);

    // parity error
    accept(0, f0 ^ (96'd1 << 95));
    wait_out(0, lat);
    chk("par_lat", 96'(lat), 96'd2);
    chk("par_err", {95'b0, err}, 96'd1);
    chk("par_data", {16'b0, out}, 96'd0);

    // mode 2 frame, amount 63
    p2 = 80'h0123_4567_89AB_CDEF_1357;
    c2 = rotl80(p2 ^ k80(9'h03F, 6'h02), 63);
    f2 = mk(9'h03F, 6'h02, c2);
    accept(1, f2);
    wait_out(1, lat);
    chk("m2s4_lat", 96'(lat), 96'd19);
    chk("m2s4_data", {16'b0, out4}, {16'b0, p2});
    chk("m2s4_err", {95'b0, err4}, 96'd0);

    // backpressure on the ROT_STEP=1 instance
    ordy = 1'b0;
    accept(0, f2);
    wait_out(0, lat);
    chk("bp_lat", 96'(lat), 96'd66);
    chk("bp_data", {16'b0, out}, {16'b0, p2});
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      chk("bp_hold_data", {16'b0, out}, {16'b0, p2});
      chk("bp_hold_valid", {95'b0, out_valid}, 96'd1);
      chk("bp_hold_ready", {95'b0, in_ready}, 96'd0);
    end
    @(negedge Clk);
    ordy = 1'b1;
    @(posedge Clk);
    #1;
    chk("bp_release_valid", {95'b0, out_valid}, 96'd0);
    chk("bp_release_ready", {95'b0, in_ready}, 96'd1);

    // reset pulse mid-ROTATE
    accept(0, f2);
    repeat (10) @(posedge Clk);
    #1;
    chk("abort_busy_before", {95'b0, busy}, 96'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("abort_ready_in_rst", {95'b0, in_ready}, 96'd0);
    chk("abort_busy_in_rst", {95'b0, busy}, 96'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("abort_valid", {95'b0, out_valid}, 96'd0);
    chk("abort_busy", {95'b0, busy}, 96'd0);
    chk("abort_data", {16'b0, out}, 96'd0);
    chk("abort_err", {95'b0, err}, 96'd0);
    chk("abort_ready", {95'b0, in_ready}, 96'd1);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge Clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", {95'b0, seen}, 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
